// File: rtl/mp3dec_pcm_pkg.sv
// Shared constants for the Mp3Decode PCM-to-I2S output stage.
// Frame layout, LRCK polarity and the mute word live here.
package mp3dec_pcm_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int FRAME_BITS = 2 * SAMPLE_W_DEF;

  localparam logic LRCK_LEFT = 1'b0;
  localparam logic LRCK_RIGHT = ~LRCK_LEFT;

  localparam logic [FRAME_BITS-1:0] MUTE_WORD = '0;

endpackage

// File: rtl/mp3dec_pcm_i2s_tx_if.sv
// Write port between Mp3Decode and the PCM I2S transmitter.
// The decoder drives Winc/Wdata and honours Wfull back-pressure.
interface mp3dec_pcm_i2s_tx_if #(
  parameter int SAMPLE_W = 16
);

  logic                  Winc;
  logic [2*SAMPLE_W-1:0] Wdata;
  logic                  Wfull;

  modport master (
    output Winc,
    output Wdata,
    input  Wfull
  );

  modport slave (
    input  Winc,
    input  Wdata,
    output Wfull
  );

endinterface

// File: rtl/mp3dec_pcm_fifo.sv
// Show-ahead synchronous FIFO holding stereo PCM words.
// Flags decode from the registered count only.
module mp3dec_pcm_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mp3dec_pcm_i2s_tx.sv
// Buffers decoded stereo PCM and serialises it as I2S.
// BCLK is divided from Clk; all I2S outputs are registered.
module mp3dec_pcm_i2s_tx
  import mp3dec_pcm_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int BCLK_DIV = 4,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Enable,
  mp3dec_pcm_i2s_tx_if.slave     wr,
  output logic [$clog2(DEPTH):0] Level,
  output logic                   Underrun,
  output logic                   I2S_BCLK,
  output logic                   I2S_LRCK,
  output logic                   I2S_SDATA
);

  localparam int FW = 2 * SAMPLE_W;
  localparam int SB = $clog2(FW);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [FW-1:0] head;
  logic          empty;
  logic          pop;

  logic [DW-1:0] div_cnt, div_d;
  logic [SB-1:0] slot_cnt, slot_d;
  logic [SB-1:0] slot_nx;
  logic [SB-1:0] bit_idx;
  logic [FW-1:0] frame, frame_d;
  logic          prev_lsb, prev_lsb_d;
  logic          bclk_d, lrck_d, sdata_d;
  logic          und_d;
  logic          tick, fall, load;

  mp3dec_pcm_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (wr.Winc),
    .pop   (pop),
    .din   (wr.Wdata),
    .dout  (head),
    .count (Level),
    .full  (wr.Wfull),
    .empty (empty)
  );

  assign tick = (div_cnt == DW'(BCLK_DIV - 1));
  assign fall = tick & I2S_BCLK;
  assign load = fall & (slot_cnt == '0);
  assign pop  = Enable & load & ~empty;

  assign slot_nx = (slot_cnt == SB'(FW - 1)) ?
                   '0 : slot_cnt + 1'b1;
  // Slot k carries frame bit FW-k; modulo arithmetic gives that index.
  assign bit_idx = SB'(FW) - slot_nx;

  always_comb begin
    div_d      = div_cnt;
    slot_d     = slot_cnt;
    frame_d    = frame;
    prev_lsb_d = prev_lsb;
    bclk_d     = I2S_BCLK;
    lrck_d     = I2S_LRCK;
    sdata_d    = I2S_SDATA;
    und_d      = Underrun;
    if (!Enable) begin
      div_d      = '0;
      slot_d     = '0;
      prev_lsb_d = 1'b0;
      bclk_d     = 1'b0;
      lrck_d     = 1'b0;
      sdata_d    = 1'b0;
      und_d      = 1'b0;
    end else begin
      div_d = tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        bclk_d = ~I2S_BCLK;
      end
      if (fall) begin
        slot_d = slot_nx;
        lrck_d = (slot_nx >= SB'(SAMPLE_W)) ?
                 LRCK_RIGHT : LRCK_LEFT;
        if (load) begin
          if (empty) begin
            frame_d = FW'(MUTE_WORD);
            sdata_d = 1'b0;
            und_d   = 1'b1;
          end else begin
            frame_d = head;
            sdata_d = head[FW-1];
          end
        end else if (slot_nx == '0) begin
          sdata_d = prev_lsb;
        end else begin
          sdata_d = frame[bit_idx];
        end
        // Keep the LSB for the one-bit-delayed slot 0 of the next frame.
        if (slot_nx == SB'(FW - 1)) begin
          prev_lsb_d = frame[0];
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      div_cnt   <= '0;
      slot_cnt  <= '0;
      frame     <= '0;
      prev_lsb  <= 1'b0;
      I2S_BCLK  <= 1'b0;
      I2S_LRCK  <= 1'b0;
      I2S_SDATA <= 1'b0;
      Underrun  <= 1'b0;
    end else begin
      div_cnt   <= div_d;
      slot_cnt  <= slot_d;
      frame     <= frame_d;
      prev_lsb  <= prev_lsb_d;
      I2S_BCLK  <= bclk_d;
      I2S_LRCK  <= lrck_d;
      I2S_SDATA <= sdata_d;
      Underrun  <= und_d;
    end
  end

endmodule

// File: tb/tb_mp3dec_pcm_i2s_tx.sv
// Directed bench for the PCM I2S transmitter.
// Main DUT uses BCLK_DIV=4; a second uses BCLK_DIV=1.
module tb_mp3dec_pcm_i2s_tx;

  typedef struct {
    logic [31:0] w;
    logic [15:0] l;
    logic [15:0] r;
    logic [4:0]  lvl;
    logic        full;
  } vec_t;

  logic Clk = 1'b0;
  logic Rst;
  logic en0, en1;
  logic [4:0] lvl0;
  logic [2:0] lvl1;
  logic und0, und1;
  logic b0, l0, s0;
  logic b1, l1, s1;

  int total = 0;
  int bad = 0;

  vec_t tv [17];

  always #5 Clk = ~Clk;

  mp3dec_pcm_i2s_tx_if #(.SAMPLE_W(16)) w0 ();
  mp3dec_pcm_i2s_tx_if #(.SAMPLE_W(16)) w1 ();

  mp3dec_pcm_i2s_tx #(
    .DEPTH(16), .BCLK_DIV(4), .SAMPLE_W(16)
  ) dut0 (
    .Clk(Clk), .Rst(Rst), .Enable(en0), .wr(w0),
    .Level(lvl0), .Underrun(und0),
    .I2S_BCLK(b0), .I2S_LRCK(l0), .I2S_SDATA(s0)
  );

  mp3dec_pcm_i2s_tx #(
    .DEPTH(4), .BCLK_DIV(1), .SAMPLE_W(16)
  ) dut1 (
    .Clk(Clk), .Rst(Rst), .Enable(en1), .wr(w1),
    .Level(lvl1), .Underrun(und1),
    .I2S_BCLK(b1), .I2S_LRCK(l1), .I2S_SDATA(s1)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic wr(input int sel, input logic [31:0] w);
    @(negedge Clk);
    if (sel == 1) begin
      w1.Winc = 1'b1; w1.Wdata = w;
    end else begin
      w0.Winc = 1'b1; w0.Wdata = w;
    end
    @(negedge Clk);
    w0.Winc = 1'b0;
    w1.Winc = 1'b0;
  endtask

  // Waits for a BCLK rising edge; samples data/LRCK there.
  task automatic next_rise(input int sel, output logic sd,
                           output logic lr, output int cyc);
    logic p;
    cyc = 0;
    sd = 1'bx;
    lr = 1'bx;
    p = (sel == 1) ? b1 : b0;
    repeat (64) begin
      @(negedge Clk);
      cyc++;
      if (!p && ((sel == 1) ? b1 : b0)) begin
        sd = (sel == 1) ? s1 : s0;
        lr = (sel == 1) ? l1 : l0;
        return;
      end
      p = (sel == 1) ? b1 : b0;
    end
    total++;
    bad++;
    $display("FAIL bclk_timeout dut=%0d got=none exp=rise", sel);
  endtask

  // Collects slots 1..31 and the next slot 0 of one frame.
  task automatic run_frame(input int sel, input logic [31:0] expw,
                           input string nm);
    logic [31:0] got, lrg;
    logic sd, lr;
    int c;
    for (int k = 1; k <= 32; k++) begin
      next_rise(sel, sd, lr, c);
      got[32-k] = sd;
      lrg[32-k] = lr;
    end
    chk({nm, "_data"}, got, expw);
    chk({nm, "_lrck"}, lrg, 32'h0001_FFFE);
  endtask

  initial begin
    logic sd, lr, pb;
    int c;

    tv[0]  = '{32'h0000_0001, 16'h0000, 16'h0001, 5'd1,  1'b0};
    tv[1]  = '{32'h8000_0000, 16'h8000, 16'h0000, 5'd2,  1'b0};
    tv[2]  = '{32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 5'd3,  1'b0};
    tv[3]  = '{32'h1234_5678, 16'h1234, 16'h5678, 5'd4,  1'b0};
    tv[4]  = '{32'hDEAD_BEEF, 16'hDEAD, 16'hBEEF, 5'd5,  1'b0};
    tv[5]  = '{32'hAAAA_5555, 16'hAAAA, 16'h5555, 5'd6,  1'b0};
    tv[6]  = '{32'h0F0F_F0F0, 16'h0F0F, 16'hF0F0, 5'd7,  1'b0};
    tv[7]  = '{32'hC001_D00D, 16'hC001, 16'hD00D, 5'd8,  1'b0};
    tv[8]  = '{32'h1357_9BDF, 16'h1357, 16'h9BDF, 5'd9,  1'b0};
    tv[9]  = '{32'h2468_ACE0, 16'h2468, 16'hACE0, 5'd10, 1'b0};
    tv[10] = '{32'h7FFF_8001, 16'h7FFF, 16'h8001, 5'd11, 1'b0};
    tv[11] = '{32'hFEDC_BA98, 16'hFEDC, 16'hBA98, 5'd12, 1'b0};
    tv[12] = '{32'h0123_4567, 16'h0123, 16'h4567, 5'd13, 1'b0};
    tv[13] = '{32'h5A5A_A5A5, 16'h5A5A, 16'hA5A5, 5'd14, 1'b0};
    tv[14] = '{32'h8001_0080, 16'h8001, 16'h0080, 5'd15, 1'b0};
    tv[15] = '{32'h6B6B_1C1C, 16'h6B6B, 16'h1C1C, 5'd16, 1'b1};
    tv[16] = '{32'h9999_9999, 16'h9999, 16'h9999, 5'd16, 1'b1};

    Rst = 1'b1;
    en0 = 1'b0;
    en1 = 1'b0;
    w0.Winc = 1'b0; w0.Wdata = '0;
    w1.Winc = 1'b0; w1.Wdata = '0;

    // Reset with a half-full FIFO
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 8; i++) wr(0, tv[i].w);
    chk("half_level", lvl0, 8);
    #2 Rst = 1'b1;
    #1;
    chk("rst_level", lvl0, 0);
    chk("rst_full", w0.Wfull, 0);
    chk("rst_outs", {b0, l0, s0, und0}, 0);
    en0 = 1'b1;
    repeat (10) @(negedge Clk);
    chk("rst_no_bclk", {b0, l0, s0}, 0);
    en0 = 1'b0;
    Rst = 1'b0;

    // Single word
    wr(0, 32'hA5A5_3C3C);
    chk("single_lvl", lvl0, 1);
    en0 = 1'b1;
    next_rise(0, sd, lr, c);
    chk("first_rise_cyc", c, 4);
    chk("slot0_sd_lr", {sd, lr}, 0);
    repeat (3) @(negedge Clk);
    chk("lvl_before_load", lvl0, 1);
    @(negedge Clk);
    chk("lvl_after_load", lvl0, 0);
    chk("slot1_outs", {b0, l0, s0}, 3'b001);
    run_frame(0, 32'hA5A5_3C3C, "single");
    chk("single_und", und0, 0);
    en0 = 1'b0;
    @(negedge Clk);
    chk("dis_outs", {b0, l0, s0, und0}, 0);

    // Back-pressure table
    for (int i = 0; i < 17; i++) begin
      wr(0, tv[i].w);
      chk("bp_level", lvl0, tv[i].lvl);
      chk("bp_full", w0.Wfull, tv[i].full);
    end
    en0 = 1'b1;
    next_rise(0, sd, lr, c);
    chk("bp_slot0", {sd, lr}, 0);
    for (int i = 0; i < 16; i++) begin
      run_frame(0, {tv[i].l, tv[i].r}, "bp");
    end
    chk("bp_und", und0, 0);
    chk("bp_empty", lvl0, 0);

    // Underrun, then recovery
    run_frame(0, 32'h0, "mute");
    chk("und_set", und0, 1);
    wr(0, 32'h0001_8000);
    run_frame(0, 32'h0001_8000, "recover");
    chk("und_held", und0, 1);
    en0 = 1'b0;
    @(negedge Clk);
    chk("und_clr", und0, 0);

    // Push in the same cycle as the slot-1 load
    wr(0, 32'h1234_5678);
    en0 = 1'b1;
    next_rise(0, sd, lr, c);
    repeat (3) @(negedge Clk);
    w0.Winc = 1'b1; w0.Wdata = 32'h9ABC_DEF0;
    @(negedge Clk);
    w0.Winc = 1'b0;
    chk("sim_lvl", lvl0, 1);
    run_frame(0, 32'h1234_5678, "sim_old");
    run_frame(0, 32'h9ABC_DEF0, "sim_new");
    chk("sim_und0", und0, 0);
    repeat (3) @(negedge Clk);
    w0.Winc = 1'b1; w0.Wdata = 32'hCAFE_F00D;
    @(negedge Clk);
    w0.Winc = 1'b0;
    chk("sim_empty_lvl", lvl0, 1);
    chk("sim_empty_und", und0, 1);
    run_frame(0, 32'h0, "sim_mute");
    en0 = 1'b0;

    // Enable drop at slot 10
    wr(0, 32'h0F1E_2D3C);
    chk("drop_lvl2", lvl0, 2);
    en0 = 1'b1;
    next_rise(0, sd, lr, c);
    for (int k = 0; k < 10; k++) next_rise(0, sd, lr, c);
    chk("drop_lvl1", lvl0, 1);
    en0 = 1'b0;
    @(negedge Clk);
    chk("drop_outs", {b0, l0, s0}, 0);
    repeat (20) @(negedge Clk);
    chk("drop_keep", {lvl0, b0}, {5'd1, 1'b0});
    en0 = 1'b1;
    next_rise(0, sd, lr, c);
    chk("reen_slot0", {sd, lr}, 0);
    run_frame(0, 32'h0F1E_2D3C, "reen");
    next_rise(0, sd, lr, c);
    chk("period4", c, 8);

    // BCLK_DIV=1 instance
    wr(1, 32'hB00B_1E55);
    en1 = 1'b1;
    next_rise(1, sd, lr, c);
    chk("d1_first_rise", c, 1);
    chk("d1_slot0", {sd, lr}, 0);
    run_frame(1, 32'hB00B_1E55, "d1");
    next_rise(1, sd, lr, c);
    chk("d1_period", c, 2);
    pb = b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk("d1_toggle", b1 ^ pb, 1);
      pb = b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
